// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register specifiers and the
// processor status encoding used by the write-back stage.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  typedef enum logic [2:0] {
    SAOK = 3'd1,
    SHLT = 3'd2,
    SADR = 3'd3,
    SINS = 3'd4
  } stat_t;

endpackage

// File: rtl/writeback_regfile.sv
// Architectural register file: 15 x DATA_W, two write ports (E and M, M wins
// on a shared destination), two combinational read ports returning 0 for RNONE.
module regfile
  import y86_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] RSP_RESET = 64'd256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        dst_e,
  input  logic [DATA_W-1:0] val_e,
  input  logic [3:0]        dst_m,
  input  logic [DATA_W-1:0] val_m,
  input  logic [3:0]        src_a,
  input  logic [3:0]        src_b,
  output logic [DATA_W-1:0] val_a,
  output logic [DATA_W-1:0] val_b
);

  logic [DATA_W-1:0] regs_q [0:14];
  logic [DATA_W-1:0] regs_d [0:14];

  // M port is applied last so popq %rsp keeps the popped value.
  always_comb begin
    for (int i = 0; i < 15; i++) begin
      regs_d[i] = regs_q[i];
      if (dst_e == 4'(i)) regs_d[i] = val_e;
      if (dst_m == 4'(i)) regs_d[i] = val_m;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 15; i++) begin
      if (reset) regs_q[i] <= (i == 4) ? RSP_RESET : '0;
      else       regs_q[i] <= regs_d[i];
    end
  end

  assign val_a = (src_a == RNONE) ? '0 : regs_q[src_a];
  assign val_b = (src_b == RNONE) ? '0 : regs_q[src_b];

endmodule

// File: rtl/writeback.sv
// Y86-64 write-back stage: destination selection, processor status FSM and the
// register file. Optional retire counter enabled by WB_RETIRE_COUNT_EN.
module writeback
  import y86_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] RSP_RESET = 64'd256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              cnd,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic              memory_error,
  input  logic              instr_valid,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic [2:0]        stat,
`ifdef WB_RETIRE_COUNT_EN
  output logic [63:0]       retired,
`endif
  output logic              halted
);

  // Handshake: there is no backpressure. When valid is high the presented
  // instruction is consumed at the next rising edge; when low, nothing changes.
  stat_t      stat_q, stat_d, new_stat;
  logic       commit;
  logic [3:0] dst_e, dst_m, wr_e, wr_m;

  always_comb begin
    dst_e = RNONE;
    dst_m = RNONE;
    case (icode)
      IRRMOVQ:                    dst_e = cnd ? rB : RNONE;
      IIRMOVQ, IOPQ:              dst_e = rB;
      ICALL, IRET, IPUSHQ, IPOPQ: dst_e = RRSP;
      default:                    dst_e = RNONE;
    endcase
    if (icode == IMRMOVQ || icode == IPOPQ) dst_m = rA;
  end

  always_comb begin
    new_stat = SAOK;
    if (memory_error)       new_stat = SADR;
    else if (!instr_valid)  new_stat = SINS;
    else if (icode == IHALT) new_stat = SHLT;
  end

  assign commit = valid && (stat_q == SAOK) && (new_stat == SAOK);
  assign wr_e   = commit ? dst_e : RNONE;
  assign wr_m   = commit ? dst_m : RNONE;

  // Non-AOK states are terminal; only reset leaves them.
  always_comb begin
    stat_d = stat_q;
    if (valid && stat_q == SAOK) stat_d = new_stat;
  end

  always_ff @(posedge clk) begin
    if (reset) stat_q <= SAOK;
    else       stat_q <= stat_d;
  end

  assign stat   = stat_q;
  assign halted = (stat_q != SAOK);

`ifdef WB_RETIRE_COUNT_EN
  logic [63:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (commit) retired_d = retired_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) retired_q <= '0;
    else       retired_q <= retired_d;
  end

  assign retired = retired_q;
`endif

  regfile #(
    .DATA_W    (DATA_W),
    .RSP_RESET (RSP_RESET)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .dst_e (wr_e),
    .val_e (valE),
    .dst_m (wr_m),
    .val_m (valM),
    .src_a (srcA),
    .src_b (srcB),
    .val_a (valA),
    .val_b (valB)
  );

endmodule

// File: tb/tb_writeback.sv
// Directed scoreboard bench for writeback: the driver queues expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_writeback;

  localparam int W = 64;

  localparam int K_A    = 0;
  localparam int K_B    = 1;
  localparam int K_STAT = 2;
  localparam int K_HALT = 3;
  localparam int K_RET  = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid;
  logic [3:0]   icode, rA, rB, srcA, srcB;
  logic         cnd, memory_error, instr_valid;
  logic [W-1:0] valE, valM, valA, valB;
  logic [2:0]   stat;
  logic         halted;
`ifdef WB_RETIRE_COUNT_EN
  logic [63:0]  retired;
`endif

  logic [W-1:0] exp_q [$];
  int           kind_q [$];
  int           tests_run = 0;
  int           tests_failed = 0;

  writeback dut (
    .clk          (clk),
    .reset        (reset),
    .valid        (valid),
    .icode        (icode),
    .rA           (rA),
    .rB           (rB),
    .cnd          (cnd),
    .valE         (valE),
    .valM         (valM),
    .memory_error (memory_error),
    .instr_valid  (instr_valid),
    .srcA         (srcA),
    .srcB         (srcB),
    .valA         (valA),
    .valB         (valB),
    .stat         (stat),
`ifdef WB_RETIRE_COUNT_EN
    .retired      (retired),
`endif
    .halted       (halted)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
    $fatal(1, "timeout");
  end

  // Driver tasks
  task automatic expect_val(input int kind, input logic [W-1:0] exp);
    kind_q.push_back(kind);
    exp_q.push_back(exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = 1'b0; icode = 4'h1; rA = 4'hF; rB = 4'hF; cnd = 1'b0;
    valE = '0; valM = '0; memory_error = 1'b0; instr_valid = 1'b1;
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic c, input logic [W-1:0] ve, input logic [W-1:0] vm,
                       input logic me, input logic iv);
    valid = 1'b1; icode = ic; rA = ra; rB = rb; cnd = c;
    valE = ve; valM = vm; memory_error = me; instr_valid = iv;
  endtask

  task automatic expect_ret(input logic [63:0] n);
`ifdef WB_RETIRE_COUNT_EN
    expect_val(K_RET, n);
`else
    if (n == 64'hFFFF_FFFF_FFFF_FFFF) $display("unreachable");
`endif
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      automatic int           k   = kind_q.pop_front();
      automatic logic [W-1:0] e   = exp_q.pop_front();
      automatic logic [W-1:0] act = '0;
      automatic string        nm  = "";
      case (k)
        K_A:    begin act = valA; nm = "valA"; end
        K_B:    begin act = valB; nm = "valB"; end
        K_STAT: begin act = W'(stat); nm = "stat"; end
        K_HALT: begin act = W'(halted); nm = "halted"; end
`ifdef WB_RETIRE_COUNT_EN
        K_RET:  begin act = retired; nm = "retired"; end
`endif
        default: begin act = ~e; nm = "unknown_kind"; end
      endcase
      tests_run++;
      if (act !== e) begin
        tests_failed++;
        $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, e);
      end
    end
  end

  // Stimulus
  initial begin
    reset = 1'b1; srcA = 4'hF; srcB = 4'hF;
    idle();
    step(); step();
    reset = 1'b0;

    // Reset state
    srcA = 4'h4; srcB = 4'h0;
    expect_val(K_A, 64'd256); expect_val(K_B, 64'd0);
    expect_val(K_STAT, 64'd1); expect_val(K_HALT, 64'd0); expect_ret(0);
    step();

    // irmovq -> r2; not visible before the edge
    drive(4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'h0, 1'b0, 1'b1);
    srcA = 4'h2; expect_val(K_A, 64'h0);
    step();
    idle(); expect_val(K_A, 64'h1234); expect_val(K_STAT, 64'd1);
    step();

    // popq %rsp: M port wins
    drive(4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'hAA, 1'b0, 1'b1);
    srcA = 4'h4; expect_val(K_A, 64'd256);
    step();
    idle(); expect_val(K_A, 64'hAA);
    step();

    // cmov not taken, then taken
    drive(4'h2, 4'h1, 4'h3, 1'b0, 64'd5, 64'h0, 1'b0, 1'b1);
    srcA = 4'h3; expect_val(K_A, 64'd0);
    step();
    idle(); expect_val(K_A, 64'd0);
    step();
    drive(4'h2, 4'h1, 4'h3, 1'b1, 64'd5, 64'h0, 1'b0, 1'b1);
    step();
    idle(); expect_val(K_A, 64'd5);
    step();

    // mrmovq writes rA from valM only
    drive(4'h5, 4'h6, 4'h2, 1'b0, 64'h40, 64'h77, 1'b0, 1'b1);
    step();
    idle(); srcA = 4'h6; srcB = 4'h2;
    expect_val(K_A, 64'h77); expect_val(K_B, 64'h1234);
    step();

    // valid low holds everything
    icode = 4'h3; rB = 4'h7; valE = 64'd99;
    step();
    idle(); srcA = 4'h7; expect_val(K_A, 64'd0); expect_ret(5);
    step();

    // reset overrides a simultaneous commit
    reset = 1'b1;
    drive(4'h3, 4'hF, 4'h5, 1'b0, 64'h55, 64'h0, 1'b0, 1'b1);
    step();
    reset = 1'b0; idle(); srcA = 4'h5; srcB = 4'h4;
    expect_val(K_A, 64'd0); expect_val(K_B, 64'd256);
    expect_val(K_STAT, 64'd1); expect_ret(0);
    step();

    // three commits then halt
    drive(4'h3, 4'hF, 4'hE, 1'b0, 64'hE, 64'h0, 1'b0, 1'b1); step();
    drive(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1); step();
    drive(4'h2, 4'h1, 4'h3, 1'b0, 64'd7, 64'h0, 1'b0, 1'b1); step();
    drive(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1); step();
    idle(); srcA = 4'hE; srcB = 4'h3;
    expect_val(K_A, 64'hE); expect_val(K_B, 64'd0);
    expect_val(K_STAT, 64'd2); expect_val(K_HALT, 64'd1); expect_ret(3);
    step();

    // writes after halt are ignored
    drive(4'h3, 4'hF, 4'h8, 1'b0, 64'd1, 64'h0, 1'b0, 1'b1); step();
    idle(); srcB = 4'h8;
    expect_val(K_B, 64'd0); expect_val(K_STAT, 64'd2); expect_ret(3);
    step();

    // reset out of HLT
    reset = 1'b1; step();
    reset = 1'b0; srcA = 4'hE;
    expect_val(K_A, 64'd0); expect_val(K_STAT, 64'd1); expect_val(K_HALT, 64'd0);
    step();

    // memory error has priority over invalid instruction
    drive(4'h6, 4'hF, 4'h1, 1'b0, 64'd9, 64'h0, 1'b1, 1'b0);
    srcA = 4'h1; step();
    idle(); expect_val(K_STAT, 64'd3); expect_val(K_A, 64'd0);
    step();
    drive(4'h6, 4'hF, 4'h1, 1'b0, 64'd9, 64'h0, 1'b0, 1'b1); step();
    idle(); expect_val(K_STAT, 64'd3); expect_val(K_A, 64'd0); expect_val(K_HALT, 64'd1);
    step();
    reset = 1'b1; step();
    reset = 1'b0; expect_val(K_STAT, 64'd1);
    step();

    // invalid instruction
    drive(4'h6, 4'hF, 4'h1, 1'b0, 64'd9, 64'h0, 1'b0, 1'b0); step();
    idle(); expect_val(K_STAT, 64'd4); expect_val(K_A, 64'd0); expect_ret(0);
    step();

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
